// File: rtl/disp_scan_if.sv
// Value-update port of the display scanner: staged BCD value, load strobe and commit acknowledge.
interface disp_scan_if #(
  parameter int unsigned NDIG = 4
);
  logic [4*NDIG-1:0] val_in;
  logic              load;
  logic              load_ack;

  modport master (output val_in, output load, input load_ack);
  modport slave  (input val_in, input load, output load_ack);
endinterface

// File: rtl/disp_scan.sv
// Time-multiplexed scan controller for a shared seven-segment decoder, with frame-aligned
// value commits, leading-zero blanking and per-digit blinking.
module disp_scan #(
  parameter int unsigned NDIG  = 4,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned GUARD = 2,
  parameter int unsigned BLINK = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  disp_scan_if.slave      bus,
  input  logic            blank_lz,
  input  logic [NDIG-1:0] blink_mask,
  output logic [4:0]      num,
  output logic [NDIG-1:0] dig_sel,
  output logic            frame_start
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned FW = (BLINK > 1) ? $clog2(BLINK) : 1;

  localparam logic [PW-1:0] PresMax  = PW'(DIV - 1);
  localparam logic [PW-1:0] GuardVal = PW'(GUARD);
  localparam logic [IW-1:0] IdxMax   = IW'(NDIG - 1);
  localparam logic [FW-1:0] FcntMax  = FW'(BLINK - 1);
  localparam logic [4:0]    NumBlank = 5'd31;

  logic [PW-1:0]     pres_q, pres_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [4*NDIG-1:0] staging_q, staging_d;
  logic              pending_q, pending_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              phase_q, phase_d;
  logic [4:0]        num_q, num_d;
  logic [NDIG-1:0]   dig_sel_q, dig_sel_d;
  logic              load_ack_q, load_ack_d;
  logic              frame_start_q, frame_start_d;

  logic       tick, boundary, commit;
  logic [3:0] digit;
  logic       blink_hit, upper_zero;

  always_comb begin
    tick     = (pres_q == PresMax);
    boundary = tick && (idx_q == IdxMax);
    commit   = boundary && pending_q;

    pres_d = tick ? '0 : pres_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end

    // A load on the boundary edge is staged only; it keeps pending set for the next frame.
    staging_d = bus.load ? bus.val_in : staging_q;
    pending_d = bus.load | (pending_q & ~boundary);
    shadow_d  = commit ? staging_q : shadow_q;

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (boundary) begin
      if (fcnt_q == FcntMax) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    digit      = '0;
    blink_hit  = 1'b0;
    upper_zero = 1'b1;
    for (int j = 0; j < int'(NDIG); j++) begin
      if (IW'(j) == idx_q) begin
        digit     = shadow_q[4*j +: 4];
        blink_hit = blink_mask[j];
      end
      if (j >= int'(idx_q) && shadow_q[4*j +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end

    num_d = {1'b0, digit};
    if (blank_lz && idx_q != '0 && upper_zero) begin
      num_d = NumBlank;
    end
    if (phase_q && blink_hit) begin
      num_d = NumBlank;
    end

    // Registered outputs are computed from next-state so they line up with pres/idx.
    dig_sel_d = '1;
    if (pres_d >= GuardVal) begin
      for (int j = 0; j < int'(NDIG); j++) begin
        if (IW'(j) == idx_d) begin
          dig_sel_d[j] = 1'b0;
        end
      end
    end
    frame_start_d = (pres_d == '0) && (idx_d == '0);
    load_ack_d    = commit;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pres_q        <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      staging_q     <= '0;
      pending_q     <= 1'b0;
      fcnt_q        <= '0;
      phase_q       <= 1'b0;
      num_q         <= NumBlank;
      dig_sel_q     <= '1;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pres_q        <= pres_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      staging_q     <= staging_d;
      pending_q     <= pending_d;
      fcnt_q        <= fcnt_d;
      phase_q       <= phase_d;
      num_q         <= num_d;
      dig_sel_q     <= dig_sel_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign num          = num_q;
  assign dig_sel      = dig_sel_q;
  assign frame_start  = frame_start_q;
  assign bus.load_ack = load_ack_q;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with DIV=4, GUARD=2, BLINK=2, NDIG=4 (16-cycle frames).
module tb_disp_scan;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       blank_lz;
  logic [3:0] blink_mask;
  logic [4:0] num;
  logic [3:0] dig_sel;
  logic       frame_start;

  disp_scan_if #(.NDIG(4)) bus ();

  disp_scan #(
    .NDIG (4),
    .DIV  (4),
    .GUARD(2),
    .BLINK(2)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .bus        (bus),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .num        (num),
    .dig_sel    (dig_sel),
    .frame_start(frame_start)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ack_at   = -1;
  bit chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Slot layout: pres = cyc%4, idx = (cyc/4)%4; enable only for pres >= 2.
  function automatic logic [3:0] exp_sel(input int c);
    logic [3:0] one;
    one = 4'b0001;
    if (c % 4 < 2) return 4'hF;
    return ~(one << ((c / 4) % 4));
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (chk_en) begin
      check_eq("load_ack", 32'(bus.load_ack), 32'(cyc == ack_at));
      check_eq("frame_start", 32'(frame_start), 32'((cyc % 16 == 0) && (cyc != 0)));
      check_eq("dig_sel", 32'(dig_sel), 32'(exp_sel(cyc)));
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_load(input int c, input logic [15:0] v, input int ack);
    goto(c);
    bus.val_in = v;
    bus.load   = 1'b1;
    ack_at     = ack;
    step();
    bus.load   = 1'b0;
  endtask

  task automatic chk_num(input int c, input int e);
    goto(c);
    check_eq("num", 32'(num), 32'(e));
  endtask

  initial begin
    bus.val_in = '0;
    bus.load   = 1'b0;
    blank_lz   = 1'b0;
    blink_mask = 4'b0000;
    RST_N      = 1'b0;
    repeat (3) step();
    check_eq("rst_num", 32'(num), 32'd31);
    check_eq("rst_dig_sel", 32'(dig_sel), 32'hF);
    check_eq("rst_load_ack", 32'(bus.load_ack), 32'd0);
    check_eq("rst_frame_start", 32'(frame_start), 32'd0);

    RST_N  = 1'b1;
    cyc    = 0;
    chk_en = 1'b1;
    check_eq("rel_dig_sel", 32'(dig_sel), 32'hF);
    check_eq("rel_frame_start", 32'(frame_start), 32'd0);
    check_eq("rel_num", 32'(num), 32'd31);

    for (int c = 1; c < 32; c++) chk_num(c, 0);

    // Mid-frame load commits at the next boundary, then scans right to left.
    do_load(37, 16'h1234, 48);
    chk_num(49, 4);
    chk_num(53, 3);
    chk_num(57, 2);
    chk_num(61, 1);

    // Load on the boundary edge waits a full frame.
    do_load(63, 16'h0042, 80);
    chk_num(81, 2);
    chk_num(85, 4);
    chk_num(89, 0);

    // Last load in a frame wins.
    do_load(98, 16'h1111, 112);
    do_load(102, 16'h2222, 112);
    chk_num(113, 2);
    chk_num(117, 2);

    goto(114);
    blank_lz = 1'b1;
    do_load(114, 16'h0007, 128);
    chk_num(129, 7);
    chk_num(133, 31);
    chk_num(137, 31);
    chk_num(141, 31);

    do_load(146, 16'h0000, 160);
    chk_num(161, 0);
    chk_num(165, 31);
    chk_num(169, 31);
    chk_num(173, 31);

    goto(174);
    blank_lz = 1'b0;
    do_load(178, 16'h0007, 192);
    chk_num(193, 7);
    chk_num(197, 0);
    chk_num(201, 0);
    chk_num(205, 0);

    // Phase is 1 for frames starting at 224 and 288, 0 for those at 256 and 272.
    goto(208);
    blink_mask = 4'b0001;
    do_load(210, 16'h5678, 224);
    chk_num(225, 31);
    chk_num(229, 7);
    chk_num(233, 6);
    chk_num(237, 5);
    chk_num(241, 31);
    chk_num(257, 8);
    chk_num(261, 7);
    chk_num(273, 8);
    chk_num(289, 31);
    chk_num(293, 7);

    // Reset while a load is pending drops it.
    do_load(305, 16'h9999, -1);
    goto(308);
    RST_N  = 1'b0;
    chk_en = 1'b0;
    step();
    step();
    check_eq("mid_rst_num", 32'(num), 32'd31);
    check_eq("mid_rst_dig_sel", 32'(dig_sel), 32'hF);
    RST_N      = 1'b1;
    blink_mask = 4'b0000;
    cyc        = 0;
    chk_en     = 1'b1;
    chk_num(1, 0);
    chk_num(5, 0);
    chk_num(17, 0);
    chk_num(21, 0);
    goto(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
# disp_scan

Time-multiplexed scan controller for the shared seven-segment decoder. It holds a 4-digit BCD display value, presents one digit at a time on the decoder's 5-bit `num` input, and drives active-low digit enables aligned with the decoder's registered `seg` output. It sits between the charging-status logic, which supplies the values, and the single decoder instance on the display pins. It also provides atomic frame-boundary value updates, leading-zero blanking and per-digit blinking.

## Interface
- `NDIG`, 4: number of digits scanned (fixed width assumptions below use 4).
- `DIV`, 50000: CLK cycles per digit slot; legal range ≥ GUARD+1.
- `GUARD`, 2: cycles at slot start with all digits disabled (anti-ghost and decoder latency); legal range ≥ 2.
- `BLINK`, 32: frames per blink half-period; legal range ≥ 1.
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset, synchronous, active-low.
- `val_in` in 16: BCD digits; [3:0] is digit0 (rightmost) … [15:12] is digit3.
- `load` in 1: single-cycle update request; `val_in` is sampled in the same cycle.
- `load_ack` out 1: one-cycle pulse when the staged value is committed to display.
- `blank_lz` in 1: enable leading-zero suppression.
- `blink_mask` in 4: bit i=1 → digit i blinks.
- `num` out 5: digit code to the decoder; 5'd31 = blank.
- `dig_sel` out 4: active-low digit enables; bit i drives digit i.
- `frame_start` out 1: high for the first cycle of each digit0 slot.

## Operation
- Reset (RST_N=0 at an edge): `pres`=0, `idx`=0, shadow=0, staging=0, `pending`=0, frame count=0, `phase`=0. Outputs: `num`=5'd31, `dig_sel`=4'b1111, `load_ack`=0, `frame_start`=0. Reset mid-frame or mid-pending discards the pending load.
- Prescaler `pres` counts 0..DIV-1 and wraps. A tick (`pres`=DIV-1) advances `idx` (0..NDIG-1, wrap to 0) at the same edge.
- Frame boundary: tick with `idx`=NDIG-1.
- Load: `load`=1 → staging<=`val_in`, `pending`<=1. A repeat `load` while pending overwrites staging; the last value wins.
- Commit at a frame-boundary edge with `pending`=1 (set before that edge): shadow<=staging, `pending`<=0, `load_ack`=1 for the following cycle.
  - If `load` coincides with the boundary edge, the value is staged only. It commits at the next boundary.
- Blink: the frame counter increments at each boundary. It wraps at BLINK-1 and toggles `phase` on wrap.
- Digit code for index i, evaluated in priority order:
  - Blank (31) if `phase`=1 and `blink_mask[i]`=1.
  - Otherwise blank if `blank_lz`=1, i≠0, and shadow digits i..3 are all zero.
  - Otherwise zero-extended shadow digit i. Values 10–15 pass through unchanged; the decoder blanks them.
- `num` is registered each cycle from the current `idx`, shadow and `phase`.
- `dig_sel`: 4'b1111 while `pres` < GUARD; otherwise bit `idx`=0 and all other bits 1.
- `frame_start`=1 when `pres`=0 and `idx`=0, except in the first cycle after reset.

## Timing
- Slot start at cycle t (`pres`=0): `num` updates at t+1 and decoder `seg` updates at t+2. `dig_sel` enables at t+GUARD (≥ t+2), so a digit is never enabled with the previous digit's segments.
- Enabled window per slot: DIV-GUARD cycles. Frame period: NDIG·DIV cycles.
- `load_ack` and `frame_start` are high in the same cycle. The committed value first appears on `num` one cycle later.
- Worst-case load-to-display: just under 2 frames; best case 1 cycle plus the decoder latency.
- Blink half-period: BLINK·NDIG·DIV cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
Common setup: DIV=4, GUARD=2, BLINK=2, NDIG=4.

- Reset/scan: hold RST_N=0 for 3 cycles, then release.
  - During reset: `num`=31, `dig_sel`=1111.
  - After release: `dig_sel` steps 1111,1111,1110,1110, then 1111,1111,1101,1101, and so on.
  - `frame_start` is high every 16 cycles.
- Load commit: `load` with `val_in`=16'h1234 mid-frame.
  - `load_ack` and `frame_start` pulse together at the next boundary.
  - `num` then reads 4,3,2,1, one value per slot.
- Load at boundary and overwrite:
  - `load` 16'h0042 on the boundary edge: no ack that frame; commits one frame later.
  - Two loads 16'h1111 then 16'h2222 in the same frame: the commit shows 2222.
- Leading zero: value 16'h0007 with `blank_lz`=1 → `num` reads 7,31,31,31. Value 16'h0000 → 0,31,31,31. With `blank_lz`=0 → 7,0,0,0.
- Blink: `blink_mask`=4'b0001, value 16'h5678 → digit0 shows 8 for 2 frames, then 31 for 2 frames; digits 1–3 are unaffected.
- Reset mid-operation: pulse RST_N low while a load is pending → no `load_ack`; shadow=0; scanning restarts at `idx`=0.
